// File: rtl/outport_uart_tx_if.sv
// Host-side bundle for the UART output port: write strobe and data in,
// serial line plus FIFO status out.
interface outport_uart_tx_if #(
  parameter int FIFO_DEPTH = 4
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  logic               in_write;
  logic [31:0]        in_data;
  logic               out_tx;
  logic               out_busy;
  logic               out_full;
  logic [LEVEL_W-1:0] out_level;
  logic               out_overflow;

  modport master (
    output in_write, in_data,
    input  out_tx, out_busy, out_full, out_level, out_overflow
  );

  modport slave (
    input  in_write, in_data,
    output out_tx, out_busy, out_full, out_level, out_overflow
  );
endinterface

// File: rtl/outport_uart_tx.sv
// 32-bit output port drained over an 8N1 UART line, bytes LSB-first,
// buffered by a small word FIFO with a sticky overflow flag.
module outport_uart_tx #(
  parameter int CLKS_PER_BIT = 434,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic               clk,
  input  logic               reset,
  outport_uart_tx_if.slave   bus
);
  localparam int LEVEL_W = $clog2(FIFO_DEPTH) + 1;
  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int BAUD_W  = $clog2(CLKS_PER_BIT);
  localparam logic [BAUD_W-1:0] BAUD_RELOAD = BAUD_W'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  // FIFO
  logic [31:0]        mem [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic [LEVEL_W-1:0] count;
  logic               overflow;
  logic               full, empty, push, pop;

  assign full  = (count == LEVEL_W'(FIFO_DEPTH));
  assign empty = (count == '0);
  // A write into a full FIFO still fits when the FSM frees a slot this cycle.
  assign push  = bus.in_write && (!full || pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of block ordering.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LEVEL_W'(1);
        2'b01:   count <= count - LEVEL_W'(1);
        default: count <= count;
      endcase
      if (bus.in_write && !push) overflow <= 1'b1;
    end
  end

  // NOTE: storage is deliberately left out of reset; emptiness is tracked by
  // count, so stale words are never read and the array maps onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= bus.in_data;
  end

  // Transmitter
  state_t            state, state_n;
  logic [BAUD_W-1:0] baud_cnt, baud_n;
  logic [2:0]        bit_idx, bit_n;
  logic [1:0]        byte_idx, byte_n;
  logic [31:0]       shreg, shreg_n;
  logic              tx, tx_n;
  logic [7:0]        cur_byte;
  logic              baud_done;

  assign baud_done = (baud_cnt == '0);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      byte_idx <= '0;
      shreg    <= '0;
      tx       <= 1'b1;
    end else begin
      state    <= state_n;
      baud_cnt <= baud_n;
      bit_idx  <= bit_n;
      byte_idx <= byte_n;
      shreg    <= shreg_n;
      tx       <= tx_n;
    end
  end

  // NOTE: every output of this block gets a default first, so no path
  // leaves a signal unassigned and no latch is inferred.
  always_comb begin
    state_n  = state;
    baud_n   = baud_cnt;
    bit_n    = bit_idx;
    byte_n   = byte_idx;
    shreg_n  = shreg;
    pop      = 1'b0;

    case (state)
      IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          shreg_n = mem[rd_ptr];
          byte_n  = '0;
          baud_n  = BAUD_RELOAD;
          state_n = START;
        end
      end
      START: begin
        if (baud_done) begin
          baud_n  = BAUD_RELOAD;
          bit_n   = '0;
          state_n = DATA;
        end else begin
          baud_n = baud_cnt - BAUD_W'(1);
        end
      end
      DATA: begin
        if (baud_done) begin
          baud_n = BAUD_RELOAD;
          if (bit_idx == 3'd7) state_n = STOP;
          else                 bit_n   = bit_idx + 3'd1;
        end else begin
          baud_n = baud_cnt - BAUD_W'(1);
        end
      end
      STOP: begin
        if (baud_done) begin
          baud_n = BAUD_RELOAD;
          if (byte_idx < 2'd3) begin
            // Next byte starts immediately; the low byte is always the one on the line.
            byte_n  = byte_idx + 2'd1;
            shreg_n = shreg >> 8;
            state_n = START;
          end else begin
            state_n = IDLE;
          end
        end else begin
          baud_n = baud_cnt - BAUD_W'(1);
        end
      end
      default: state_n = IDLE;
    endcase

    // Line level is registered from the next state so out_tx has no input path.
    cur_byte = shreg_n[7:0];
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = cur_byte[bit_n];
      default: tx_n = 1'b1;
    endcase
  end

  assign bus.out_tx       = tx;
  assign bus.out_busy     = (state != IDLE);
  assign bus.out_full     = full;
  assign bus.out_level    = count;
  assign bus.out_overflow = overflow;
endmodule

// File: tb/tb_outport_uart_tx.sv
// Self-checking bench: cycle-accurate word-level model of the UART port
// compared against the DUT every cycle, plus directed corner cases.
module tb_outport_uart_tx;
  localparam int CPB   = 4;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;
  localparam int WORD  = 4 * FRAME;

  logic clk;
  logic reset;

  outport_uart_tx_if #(.FIFO_DEPTH(DEPTH)) bus ();

  outport_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: queued words, plus the word on the line and the cycles it has left.
  logic [31:0] mq[$];
  logic [31:0] m_cur = '0;
  int          m_rem = 0;
  logic        m_ovf = 1'b0;
  bit          m_pop, m_acc;

  initial begin
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        mq.delete();
        m_rem = 0;
        m_ovf = 1'b0;
      end else begin
        m_pop = (m_rem == 0) && (mq.size() > 0);
        m_acc = bus.in_write && ((mq.size() < DEPTH) || m_pop);
        if (bus.in_write && !m_acc) m_ovf = 1'b1;
        if (m_pop) begin
          m_cur = mq.pop_front();
          m_rem = WORD;
        end else if (m_rem > 0) begin
          m_rem--;
        end
        if (m_acc) mq.push_back(bus.in_data);
      end
    end
  end

  // Expected line level from elapsed time within the word: start, 8 data, stop per byte.
  function automatic logic exp_tx();
    int e, bi, p;
    if (m_rem == 0) return 1'b1;
    e  = WORD - m_rem;
    bi = e / FRAME;
    p  = (e % FRAME) / CPB;
    if (p == 0) return 1'b0;
    if (p == 9) return 1'b1;
    return m_cur[bi*8 + p - 1];
  endfunction

  task automatic compare_all();
    check("tx",       32'(bus.out_tx),       32'(exp_tx()));
    check("busy",     32'(bus.out_busy),     32'(m_rem > 0));
    check("level",    32'(bus.out_level),    32'(mq.size()));
    check("full",     32'(bus.out_full),     32'(mq.size() == DEPTH));
    check("overflow", 32'(bus.out_overflow), 32'(m_ovf));
  endtask

  // One cycle: check outputs at the falling edge, then drive the next inputs.
  task automatic step(input logic wr, input logic [31:0] d);
    @(negedge clk);
    compare_all();
    bus.in_write = wr;
    bus.in_data  = d;
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom);
  endtask

  task automatic drain(input int budget);
    int i;
    i = 0;
    while ((m_rem != 0 || mq.size() != 0) && i < budget) begin
      step(1'b0, $urandom);
      i++;
    end
    check("drain_timeout", 32'(i < budget), 32'd1);
    idle_cycles(3);
  endtask

  task automatic wait_rem(input int target, input int budget);
    int i;
    i = 0;
    while (m_rem != target && i < budget) begin
      step(1'b0, $urandom);
      i++;
    end
    check("wait_timeout", 32'(i < budget), 32'd1);
  endtask

  task automatic hold_reset(input int n);
    reset = 1'b1;
    bus.in_write = 1'b0;
    idle_cycles(n);
    reset = 1'b0;
  endtask

  int busy_n;

  initial begin
    reset = 1'b1;
    bus.in_write = 1'b0;
    bus.in_data  = '0;
    idle_cycles(3);

    // Single word straight out of reset; write presented on the first edge after release.
    reset = 1'b0;
    bus.in_write = 1'b1;
    bus.in_data  = 32'h0000_00A5;
    step(1'b0, $urandom);
    check("first_write_level", 32'(bus.out_level), 32'd1);
    check("first_write_tx", 32'(bus.out_tx), 32'd1);
    busy_n = 0;
    for (int i = 0; i < WORD + 10; i++) begin
      step(1'b0, $urandom);
      if (bus.out_busy) busy_n++;
    end
    check("busy_len", 32'(busy_n), 32'(WORD));

    // Byte ordering within a word.
    step(1'b1, 32'h4433_2211);
    drain(WORD + 20);

    // Fill the FIFO, write on the pop cycle, then overflow.
    hold_reset(2);
    for (int i = 0; i < 5; i++) step(1'b1, $urandom);
    step(1'b0, $urandom);
    check("five_level", 32'(bus.out_level), 32'(DEPTH));
    check("five_full", 32'(bus.out_full), 32'd1);
    check("five_ovf", 32'(bus.out_overflow), 32'd0);
    wait_rem(1, WORD + 10);
    step(1'b0, $urandom);
    step(1'b1, 32'hCAFE_0001);
    step(1'b0, $urandom);
    check("simul_level", 32'(bus.out_level), 32'(DEPTH));
    check("simul_ovf", 32'(bus.out_overflow), 32'd0);
    step(1'b1, 32'hDEAD_BEEF);
    step(1'b0, $urandom);
    check("drop_ovf", 32'(bus.out_overflow), 32'd1);
    check("drop_level", 32'(bus.out_level), 32'(DEPTH));
    drain(6 * (WORD + 1));

    // Reset in the middle of byte 2 with three words waiting.
    hold_reset(2);
    for (int i = 0; i < 4; i++) step(1'b1, $urandom);
    wait_rem(WORD - (2 * FRAME + 3 * CPB), WORD + 10);
    check("pre_rst_level", 32'(bus.out_level), 32'd3);
    #2 reset = 1'b1;
    #1;
    check("rst_tx", 32'(bus.out_tx), 32'd1);
    check("rst_level", 32'(bus.out_level), 32'd0);
    check("rst_busy", 32'(bus.out_busy), 32'd0);
    idle_cycles(2);
    reset = 1'b0;
    step(1'b1, 32'h1234_5678);
    drain(WORD + 20);

    // Two words far apart: line idles high in between.
    step(1'b1, $urandom);
    idle_cycles(200);
    step(1'b1, $urandom);
    idle_cycles(200);

    // Random traffic with occasional bursts that overrun the FIFO.
    hold_reset(2);
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(0, 199) == 0) begin
        for (int k = 0; k < 6; k++) step(1'b1, $urandom);
      end else begin
        step($urandom_range(0, 49) == 0, $urandom);
      end
    end
    drain(8 * (WORD + 1));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/outport_uart_tx.md
OUTPORT_UART_TX -- requirements
Module: outport_uart_tx

Interface
REQ-001 SHALL provide parameter CLKS_PER_BIT, default 434, clock cycles per serial bit (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 SHALL provide parameter FIFO_DEPTH, default 4, word entries in the transmit FIFO; power of two, 2..16.
REQ-003 SHALL have port clk, input, 1, single system clock; all state changes on its rising edge.
REQ-004 SHALL have port reset, input, 1, asynchronous active-high reset.
REQ-005 SHALL have port in_write, input, 1, one-cycle strobe, same strobe that loads the output port register.
REQ-006 SHALL have port in_data, input, 32, word to transmit, sampled when in_write=1.
REQ-007 SHALL have port out_tx, output, 1, serial line, 8N1, idle high.
REQ-008 SHALL have port out_busy, output, 1, high while any frame is on the line.
REQ-009 SHALL have port out_full, output, 1, FIFO holds FIFO_DEPTH words.
REQ-010 SHALL have port out_level, output, clog2(FIFO_DEPTH)+1, words currently queued, excluding the word being shifted.
REQ-011 SHALL have port out_overflow, output, 1, sticky flag: a write was dropped.

Function
REQ-012 SHALL accept a write when in_write=1 and FIFO not full after this cycle's pop; accepted word visible in out_level after the same edge.
REQ-013 SHALL drop a write arriving when full with no same-cycle pop, set out_overflow on that edge, and leave FIFO contents unchanged.
REQ-014 SHALL pop and write simultaneously when full and the FSM pops in that cycle; out_level then stays FIFO_DEPTH and out_overflow stays unchanged.
REQ-015 SHALL wrap FIFO read/write pointers modulo FIFO_DEPTH; full/empty derived from an extra pointer bit or from the count, never ambiguous.
REQ-016 SHALL implement FSM states IDLE, START, DATA, STOP.
REQ-017 IDLE: out_tx=1; if FIFO non-empty, pop the head word into a 32-bit shift register, byte index=0, go to START.
REQ-018 START: out_tx=0 for CLKS_PER_BIT cycles, then go to DATA, bit index=0.
REQ-019 DATA: out_tx = current byte bit[index], LSB first, each held CLKS_PER_BIT cycles; after bit 7, go to STOP.
REQ-020 STOP: out_tx=1 for CLKS_PER_BIT cycles; then, if byte index<3, increment it and go straight to START (no idle gap); otherwise go to IDLE.
REQ-021 SHALL transmit bytes of a word in order in_data[7:0], [15:8], [23:16], [31:24].
REQ-022 SHALL register out_tx; no combinational path from in_write or in_data to out_tx.
REQ-023 Latency: word written on edge E0 into an empty FIFO with FSM in IDLE -> out_tx falls on edge E1; word occupies exactly 40*CLKS_PER_BIT cycles from E1.
REQ-024 Back-to-back words: FSM spends exactly one cycle in IDLE between the last stop bit of one word and the start bit of the next.
REQ-025 out_busy SHALL be 1 in START, DATA, STOP and 0 in IDLE.
REQ-026 Baud counter SHALL be a down-counter of width clog2(CLKS_PER_BIT), reloaded on every bit boundary; no drift across 40 bits.
REQ-027 in_data changes while in_write=0 SHALL have no effect.

Reset
REQ-028 On reset assertion, asynchronously: out_tx=1, out_busy=0, out_full=0, out_level=0, out_overflow=0, FSM=IDLE, pointers and counters=0.
REQ-029 Reset mid-frame SHALL abort the frame immediately (line returns high) and discard all queued words; FIFO data storage need not be cleared.
REQ-030 First write SHALL be accepted on the first rising edge after reset deasserts.

Verification (CLKS_PER_BIT=4, FIFO_DEPTH=4)
REQ-031 Single write 0x000000A5 into idle block -> out_tx low on next edge; line pattern 0,1,0,1,0,0,1,0,1,1 (4 cycles each) then three frames 0,00000000,1; out_busy high 160 cycles.
REQ-032 Write 0x44332211 -> frames carry bytes 0x11, 0x22, 0x33, 0x44 in order, stop bit of byte n adjacent to start bit of byte n+1.
REQ-033 Five writes on consecutive cycles while idle -> first popped, next four queued, out_level=4, out_full=1, no overflow; sixth write while full -> out_overflow=1, sixth word never transmitted.
REQ-034 Full FIFO, write coinciding with the FSM pop cycle -> write accepted, out_level remains 4, out_overflow remains 0.
REQ-035 Assert reset during DATA of byte 2 with 3 words queued -> out_tx=1 and out_level=0 before next edge; after release, new write 0x12345678 transmits cleanly with no remnant bits.
REQ-036 Two words written 200 cycles apart -> each takes 160 cycles; out_tx idle high and out_busy=0 in the gap.
